// File: rtl/icache_direct_pkg.sv
// Shared widths, FSM state type and address helpers for the direct-mapped I-cache.
package mips_cache_pkg;
  localparam int DEF_LINES  = 16;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int OFFSET_W   = $clog2(DEF_WORDS);
  localparam int INDEX_W    = $clog2(DEF_LINES);
  localparam int TAG_W      = DEF_ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef enum logic {IDLE, REFILL} state_e;

  // Clears the word-offset and byte bits so beats walk the line from word 0.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned off_w);
    return addr & ~((64'd1 << (off_w + 2)) - 64'd1);
  endfunction
endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and instruction-memory-side signals of the I-cache.
interface icache_direct_if #(parameter int ADDR_W = 32);
  logic              cpu_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_inst;
  logic              cpu_stall;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_rdata;

  modport slave (input cpu_en, cpu_addr, flush, mem_valid, mem_rdata,
                 output cpu_inst, cpu_stall, mem_req, mem_addr);
  modport master (output cpu_en, cpu_addr, flush, mem_valid, mem_rdata,
                  input cpu_inst, cpu_stall, mem_req, mem_addr);
endinterface

// File: rtl/icache_direct_line_store.sv
// Flop-based valid/tag/data arrays: combinational read, whole-line write, flush-all.
module icache_line_store
  import mips_cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int TW    = TAG_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(LINES)-1:0]         i_rd_index,
  input  logic [$clog2(WORDS)-1:0]         i_rd_offset,
  output logic                             o_rd_valid,
  output logic [TW-1:0]                    o_rd_tag,
  output logic [31:0]                      o_rd_word,
  input  logic                             i_wr_en,
  input  logic                             i_wr_valid,
  input  logic [$clog2(LINES)-1:0]         i_wr_index,
  input  logic [TW-1:0]                    i_wr_tag,
  input  logic [WORDS-1:0][31:0]           i_wr_line,
  input  logic                             i_flush
);
  logic [LINES-1:0]                  r_valid;
  logic [LINES-1:0][TW-1:0]          r_tag;
  logic [LINES-1:0][WORDS-1:0][31:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else begin
      if (i_flush) r_valid <= '0;
      if (i_wr_en) r_valid[i_wr_index] <= i_wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_word  = r_data[i_rd_index][i_rd_offset];
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only I-cache: zero-latency hits, in-order multi-beat line refill on miss.
module icache_direct
  import mips_cache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  icache_direct_if.slave  bus
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW - OW - 2;

  state_e                  r_state, w_next;
  logic                    w_start;
  logic [OW-1:0]           r_beat;
  logic [IW-1:0]           r_idx;
  logic [TW-1:0]           r_tag;
  logic [ADDR_W-1:0]       r_base;
  logic                    r_poison;
  logic [WORDS-1:0][31:0]  r_stage, w_line;

  logic [OW-1:0]           w_offset;
  logic [IW-1:0]           w_index;
  logic [TW-1:0]           w_tag;
  logic                    w_rd_valid, w_hit, w_last;
  logic [TW-1:0]           w_rd_tag;
  logic [31:0]             w_rd_word;
  logic                    w_unused_lsb;

  assign w_offset     = bus.cpu_addr[OW+1:2];
  assign w_index      = bus.cpu_addr[OW+2 +: IW];
  assign w_tag        = bus.cpu_addr[ADDR_W-1 -: TW];
  assign w_unused_lsb = ^bus.cpu_addr[1:0];

  assign w_hit  = bus.cpu_en & w_rd_valid & (w_rd_tag == w_tag) & (r_state == IDLE);
  assign w_last = (r_state == REFILL) & bus.mem_valid & (r_beat == OW'(WORDS - 1));

  // Stall is gated by reset so the fetch stage is released while reset is held.
  assign bus.cpu_stall = rst & ((bus.cpu_en & ~w_hit) | (r_state == REFILL));
  assign bus.cpu_inst  = (rst & w_hit) ? w_rd_word : 32'd0;
  assign bus.mem_req   = (r_state == REFILL);
  assign bus.mem_addr  = r_base + ADDR_W'({r_beat, 2'b00});

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE:    if (bus.cpu_en && !w_hit) begin w_next = REFILL; w_start = 1'b1; end
      REFILL:  if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat   <= '0;
      r_idx    <= '0;
      r_tag    <= '0;
      r_base   <= '0;
      r_poison <= 1'b0;
    end else if (w_start) begin
      r_idx    <= w_index;
      r_tag    <= w_tag;
      r_base   <= ADDR_W'(line_base(64'(bus.cpu_addr), OW));
      r_beat   <= '0;
      r_poison <= 1'b0;
    end else if (r_state == REFILL) begin
      if (bus.flush)     r_poison <= 1'b1;
      if (bus.mem_valid) r_beat   <= r_beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == REFILL && bus.mem_valid) r_stage[r_beat] <= bus.mem_rdata;
  end

  // The last beat bypasses the staging buffer so the line installs on that edge.
  always_comb begin
    w_line         = r_stage;
    w_line[r_beat] = bus.mem_rdata;
  end

  icache_line_store #(.LINES(LINES), .WORDS(WORDS), .TW(TW)) u_store (
    .clk         (clk),
    .rst         (rst),
    .i_rd_index  (w_index),
    .i_rd_offset (w_offset),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_word   (w_rd_word),
    .i_wr_en     (w_last),
    .i_wr_valid  (~(r_poison | bus.flush)),
    .i_wr_index  (r_idx),
    .i_wr_tag    (r_tag),
    .i_wr_line   (w_line),
    .i_flush     (bus.flush)
  );
endmodule
